// File: rtl/uart_tx_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_drain_if
//  Description : Bundle between the FIFO read side / config registers and the
//                UART TX drain: empty flag, read data, pop strobe, parity
//                configuration and the serial line with its busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  r_inc;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    // FIFO/config side: supplies data and configuration, sees pops and the line
    modport master (
        output rempty,
        output rd_data,
        output par_en,
        output par_typ,
        input  r_inc,
        input  tx_out,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  rempty,
        input  rd_data,
        input  par_en,
        input  par_typ,
        output r_inc,
        output tx_out,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_drain
//  Description : UART transmitter draining an async FIFO read port. Pops one
//                word per frame with a single-cycle strobe and serialises it
//                as start, data (LSB first), optional parity, stop. One bit
//                per tx_clk cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic      tx_clk,
    input  wire logic      tx_rst,
    uart_tx_drain_if.slave bus
);

    // Counter just wide enough to index the payload bits (min 1 bit).
    localparam int                 c_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_shift;      // bits still to be sent, LSB next
    logic [DATA_WIDTH-1:0] r_byte;       // untouched copy for parity
    logic [c_CNT_W-1:0]    r_cnt;        // index of the data bit on the line
    logic                  r_par_en;     // config frozen at the fetch edge
    logic                  r_par_typ;
    logic                  r_tx_out;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_tx_out_nxt;
    logic                  w_busy_nxt;
    logic                  w_load;
    logic                  w_fetch;
    logic                  w_parity;

    // Pop only where a new frame may begin. Held off during reset because the
    // FIFO would advance on an edge where this block cannot capture the word.
    assign w_fetch = ~tx_rst & ~bus.rempty & ((r_state == IDLE) | (r_state == STOP));

    // Parity from the captured byte: even -> XOR, odd -> XNOR.
    assign w_parity = r_par_typ ? ~^r_byte : ^r_byte;

    // Next-state and next-output decode; outputs are registered so the line
    // changes on the same edge as the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_tx_out_nxt = r_tx_out;
        w_busy_nxt   = r_busy;
        w_load       = 1'b0;

        case (r_state)
            IDLE, STOP: begin
                if (w_fetch) begin
                    // Back-to-back fetch from STOP leaves no idle gap.
                    w_state_nxt  = START;
                    w_shift_nxt  = bus.rd_data;
                    w_load       = 1'b1;
                    w_tx_out_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_state_nxt  = IDLE;
                    w_tx_out_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                end
            end

            START: begin
                w_state_nxt  = DATA;
                w_tx_out_nxt = r_shift[0];
                w_shift_nxt  = r_shift >> 1;
                w_cnt_nxt    = '0;
            end

            DATA: begin
                if (r_cnt == c_LAST_BIT) begin
                    if (r_par_en) begin
                        w_state_nxt  = PARITY;
                        w_tx_out_nxt = w_parity;
                    end else begin
                        w_state_nxt  = STOP;
                        w_tx_out_nxt = 1'b1;
                    end
                end else begin
                    w_tx_out_nxt = r_shift[0];
                    w_shift_nxt  = r_shift >> 1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end

            PARITY: begin
                w_state_nxt  = STOP;
                w_tx_out_nxt = 1'b1;
            end

            default: begin
                w_state_nxt  = IDLE;
                w_tx_out_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // State register; reset parks the machine in IDLE.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and line registers; async reset forces the line idle at once.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_shift   <= '0;
            r_byte    <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tx_out <= w_tx_out_nxt;
            r_busy   <= w_busy_nxt;
            if (w_load) begin
                r_byte    <= bus.rd_data;
                r_par_en  <= bus.par_en;
                r_par_typ <= bus.par_typ;
            end
        end
    end

    assign bus.r_inc  = w_fetch;
    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART transmitter that sits directly downstream of the async FIFO read side, in the UART TX clock domain.
- Watches the FIFO empty flag and pops one byte per frame with a single-cycle read strobe.
- Serialises each byte as start, data (LSB first), optional parity, stop onto the serial line.
- tx_clk is the bit clock: one bit per cycle. Any baud division is done upstream by the clock divider.

Parameters:
- DATA_WIDTH, 8, width of the FIFO read data and of the serial payload.

Ports:
- tx_clk  input  1  bit clock; all state changes on its rising edge.
- tx_rst  input  1  asynchronous, active-high reset.
- rempty  input  1  FIFO empty flag, already in the tx_clk domain.
- rd_data  input  DATA_WIDTH  FIFO read data at the current read address; valid while rempty=0.
- r_inc  output  1  FIFO pop strobe; one cycle per popped word.
- par_en  input  1  1 = append parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Reset and clocking: one clock (tx_clk); reset tx_rst is asynchronous, active-high.
- Reset values: state=IDLE, tx_out=1, busy=0, r_inc=0, shift register=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP.
- r_inc is combinational: r_inc = ~rempty & (state==IDLE | state==STOP). It never asserts while rempty=1.
- Fetch edge: a rising edge with r_inc=1.
  - rd_data is loaded into the shift register.
  - par_en and par_typ are latched.
  - State becomes START.
- Registered outputs update at the same edge as the state change. Each state lasts exactly one cycle, except DATA.
  - START: tx_out=0, busy=1, for 1 cycle, then DATA.
  - DATA: tx_out = shift[0]; shift right each cycle; counter runs 0..DATA_WIDTH-1. DATA lasts DATA_WIDTH cycles, then PARITY if the latched par_en=1, else STOP.
  - PARITY: tx_out = ^byte when latched par_typ=0, ~^byte when par_typ=1. The parity is computed from the captured byte, not the shifted register. Lasts 1 cycle, then STOP.
  - STOP: tx_out=1 for 1 cycle. Then:
    - if rempty=0 during the STOP cycle: fetch (r_inc=1) and go to START. This is back-to-back with no idle cycle.
    - else: go to IDLE, busy=0, tx_out stays 1.
- Frame length: 1 + DATA_WIDTH + par_en + 1 cycles. That is 10 cycles with parity off and 11 with parity on, at DATA_WIDTH=8.
- Latency: from the fetch edge, the start bit appears on tx_out immediately after that edge.
- Config stability: par_en/par_typ changes mid-frame do not affect the current frame. They apply from the next fetch edge.
- rempty toggling mid-frame is ignored. It is only sampled in IDLE and STOP.
- Reset mid-frame:
  - tx_out returns to 1 and busy to 0 immediately, without waiting for a clock edge.
  - The byte in flight is dropped, not re-read. The FIFO pointer has already advanced.
  - After release, the block sits in IDLE and fetches at the first edge where rempty=0.
- Pops: exactly one r_inc pulse per transmitted frame; never two pops within one frame.

Test Plan:
- Reset: assert tx_rst mid-DATA of byte 0xA5 -> tx_out=1 and busy=0 before the next edge. No r_inc until release with rempty=0. The first post-reset frame carries the next FIFO word, not 0xA5.
- Single byte, no parity: rempty drops with rd_data=0x35, par_en=0 -> one r_inc pulse. tx_out sequence is 0,1,0,1,0,1,1,0,0,1 over 10 cycles. busy high for exactly 10 cycles, then IDLE.
- Even/odd parity: byte 0x07 with par_en=1 -> parity bit 1 for par_typ=0 and 0 for par_typ=1. Frame is 11 cycles.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x5A; rempty stays 0 -> three r_inc pulses, each in a STOP cycle except the first. Streams are contiguous with no idle-high gap. The stop bit is 1 between frames.
- Empty guard: rempty held 1 for 50 cycles -> r_inc never asserts, tx_out=1, busy=0. rempty rising during DATA does not truncate the frame.
- Config change mid-frame: toggle par_en from 0 to 1 during DATA -> the current frame stays 10 cycles; the next frame is 11 cycles.
